// File: rtl/ripple_pkg.sv
// Shared definitions for the ripple counter capture slice: FSM states,
// default bus widths and the classification of accepted count transitions.
package ripple_pkg;

  localparam int DEF_WIDTH      = 6;
  localparam int DEF_WRAP_W     = 4;
  localparam int DEF_STABLE_CYC = 2;

  typedef enum logic {
    SETTLE = 1'b0,
    TRACK  = 1'b1
  } cap_state_t;

  typedef enum logic [1:0] {
    INC  = 2'd0,
    WRAP = 2'd1,
    CLR  = 2'd2,
    ERR  = 2'd3
  } trans_t;

endpackage

// File: rtl/ripple_count_capture_if.sv
// Snapshot request/acknowledge bundle between the control logic (master)
// and the ripple count capture block (slave).
interface ripple_count_capture_if
  import ripple_pkg::*;
#(
  parameter int DATA_W = DEF_WIDTH + DEF_WRAP_W
);

  logic              capture_req;
  logic              capture_ack;
  logic [DATA_W-1:0] capture_data;

  modport master (
    output capture_req,
    input  capture_ack,
    input  capture_data
  );

  modport slave (
    input  capture_req,
    output capture_ack,
    output capture_data
  );

endinterface

// File: rtl/bus_stable_filter.sv
// Two-flop synchronizer for an asynchronous bus followed by a stability filter:
// a value is offered (o_accept) once it has been seen STABLE_CYC times in a row.
module bus_stable_filter
  import ripple_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int STABLE_CYC = DEF_STABLE_CYC
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_bus,
  output logic [WIDTH-1:0] o_value,
  output logic             o_accept
);

  localparam int                STAB_W   = 3;
  localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_CYC - 1);
  localparam logic [STAB_W-1:0] STAB_ONE = STAB_W'(1);

  logic [WIDTH-1:0]  r_s1;
  logic [WIDTH-1:0]  r_s2;
  logic [WIDTH-1:0]  r_last;
  logic              r_v1;
  logic              r_v2;
  logic              r_have;
  logic [STAB_W-1:0] r_stab;
  logic              w_accept;

  // r_v1/r_v2 mark sync stages holding real samples, so the zeroed
  // flops right after reset are never mistaken for a stable value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1   <= '0;
      r_s2   <= '0;
      r_v1   <= 1'b0;
      r_v2   <= 1'b0;
      r_stab <= '0;
      r_last <= '0;
      r_have <= 1'b0;
    end else begin
      r_s1 <= i_bus;
      r_s2 <= r_s1;
      r_v1 <= 1'b1;
      r_v2 <= r_v1;
      if (r_v1 && r_v2 && (r_s1 == r_s2)) begin
        if (r_stab != STAB_MAX) begin
          r_stab <= r_stab + STAB_ONE;
        end
      end else begin
        r_stab <= '0;
      end
      if (w_accept) begin
        r_last <= r_s2;
        r_have <= 1'b1;
      end
    end
  end

  assign w_accept = r_v2 && (r_stab == STAB_MAX) && (!r_have || (r_s2 != r_last));
  assign o_value  = r_s2;
  assign o_accept = w_accept;

endmodule

// File: rtl/ripple_count_capture.sv
// Consumer of an asynchronous ripple counter: filters the count, tracks wraps,
// clears and sequence errors, and serves {wrap_cnt, count_q} snapshots.
// Optional macro RIPPLE_CAPTURE_WRAP_SAT_EN: saturating wrap_cnt plus wrap_ovf.
module ripple_count_capture
  import ripple_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int WRAP_W     = DEF_WRAP_W,
  parameter int STABLE_CYC = DEF_STABLE_CYC
) (
  input  logic              clock,
  input  logic              clear,
  input  logic [WIDTH-1:0]  count_in,
  output logic [WIDTH-1:0]  count_q,
  output logic              count_valid,
  output logic              wrap_pulse,
  output logic              clear_seen,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic              seq_err,
`ifdef RIPPLE_CAPTURE_WRAP_SAT_EN
  output logic              wrap_ovf,
`endif
  ripple_count_capture_if.slave cap_if
);

  localparam logic [WIDTH-1:0]  CNT_ONE  = WIDTH'(1);
  localparam logic [WRAP_W-1:0] WRAP_ONE = WRAP_W'(1);

  cap_state_t              r_state;
  cap_state_t              w_state_next;
  logic [WIDTH-1:0]        r_count_q;
  logic [WIDTH-1:0]        w_count_q_next;
  logic                    r_valid;
  logic                    w_valid_next;
  logic                    r_wrap_pulse;
  logic                    w_wrap_pulse_next;
  logic                    r_clear_seen;
  logic                    w_clear_seen_next;
  logic [WRAP_W-1:0]       r_wrap_cnt;
  logic [WRAP_W-1:0]       w_wrap_cnt_next;
  logic                    r_seq_err;
  logic                    w_seq_err_next;
  logic                    r_ack;
  logic                    w_ack_next;
  logic [WIDTH+WRAP_W-1:0] r_data;
  logic [WIDTH+WRAP_W-1:0] w_data_next;
  logic                    r_ack_block;
  logic                    w_ack_block_next;
  logic                    r_ovf;
  logic                    w_ovf_next;
  logic [WIDTH-1:0]        w_cand;
  logic                    w_accept;
  trans_t                  w_trans;

  bus_stable_filter #(
    .WIDTH      (WIDTH),
    .STABLE_CYC (STABLE_CYC)
  ) u_filter (
    .clk      (clock),
    .rst_n    (clear),
    .i_bus    (count_in),
    .o_value  (w_cand),
    .o_accept (w_accept)
  );

  function automatic trans_t classify(input logic [WIDTH-1:0] o, input logic [WIDTH-1:0] n);
    logic [WIDTH-1:0] succ;
    succ = o + CNT_ONE;
    if (n == succ) return (o == '1) ? WRAP : INC;
    if (n == '0)   return CLR;
    return ERR;
  endfunction

  assign w_trans = classify(r_count_q, w_cand);

  always_comb begin
    w_state_next      = r_state;
    w_count_q_next    = r_count_q;
    w_valid_next      = r_valid;
    w_wrap_pulse_next = 1'b0;
    w_clear_seen_next = 1'b0;
    w_wrap_cnt_next   = r_wrap_cnt;
    w_seq_err_next    = r_seq_err;
    w_ack_next        = 1'b0;
    w_data_next       = r_data;
    w_ack_block_next  = r_ack_block;
    w_ovf_next        = r_ovf;
    case (r_state)
      SETTLE: begin
        if (w_accept) begin
          w_count_q_next = w_cand;
          w_valid_next   = 1'b1;
          w_state_next   = TRACK;
        end
      end
      TRACK: begin
        // Snapshot uses the registered values, i.e. before any acceptance this cycle.
        if (cap_if.capture_req && !r_ack_block) begin
          w_ack_next       = 1'b1;
          w_data_next      = {r_wrap_cnt, r_count_q};
          w_ack_block_next = 1'b1;
        end
        if (w_accept) begin
          w_count_q_next = w_cand;
          case (w_trans)
            WRAP: begin
              w_wrap_pulse_next = 1'b1;
`ifdef RIPPLE_CAPTURE_WRAP_SAT_EN
              if (r_wrap_cnt == '1) begin
                w_ovf_next = 1'b1;
              end else begin
                w_wrap_cnt_next = r_wrap_cnt + WRAP_ONE;
              end
`else
              w_wrap_cnt_next = r_wrap_cnt + WRAP_ONE;
`endif
            end
            CLR: begin
              w_clear_seen_next = 1'b1;
              w_wrap_cnt_next   = '0;
            end
            ERR:     w_seq_err_next = 1'b1;
            default: ;
          endcase
        end
      end
      default: w_state_next = SETTLE;
    endcase
    if (!cap_if.capture_req) begin
      w_ack_block_next = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!clear) begin
      r_state      <= SETTLE;
      r_count_q    <= '0;
      r_valid      <= 1'b0;
      r_wrap_pulse <= 1'b0;
      r_clear_seen <= 1'b0;
      r_wrap_cnt   <= '0;
      r_seq_err    <= 1'b0;
      r_ack        <= 1'b0;
      r_data       <= '0;
      r_ack_block  <= 1'b0;
      r_ovf        <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_count_q    <= w_count_q_next;
      r_valid      <= w_valid_next;
      r_wrap_pulse <= w_wrap_pulse_next;
      r_clear_seen <= w_clear_seen_next;
      r_wrap_cnt   <= w_wrap_cnt_next;
      r_seq_err    <= w_seq_err_next;
      r_ack        <= w_ack_next;
      r_data       <= w_data_next;
      r_ack_block  <= w_ack_block_next;
      r_ovf        <= w_ovf_next;
    end
  end

  assign count_q             = r_count_q;
  assign count_valid         = r_valid;
  assign wrap_pulse          = r_wrap_pulse;
  assign clear_seen          = r_clear_seen;
  assign wrap_cnt            = r_wrap_cnt;
  assign seq_err             = r_seq_err;
  assign cap_if.capture_ack  = r_ack;
  assign cap_if.capture_data = r_data;
`ifdef RIPPLE_CAPTURE_WRAP_SAT_EN
  assign wrap_ovf = r_ovf;
`endif

endmodule
